// File: rtl/cp0_unit.sv
// cp0_unit -- system coprocessor 0 for the pipelined MIPS core.
//
// Holds SR(12), Cause(13), EPC(14) and PRId(15). It arbitrates level-sensitive
// hardware interrupts against the synchronous exception code coming out of the
// M stage, and it raises a flush/redirect request in the same cycle.
//
// Optional build macro CP0_TIMER_EN adds three things:
//   - Count(9), a free-running counter.
//   - Compare(11).
//   - A sticky timer interrupt TI. TI ORs into IP[15] and reads back as Cause[30].
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-low reset
//   A1 / CP0_sel       mfc0 register number / read strobe; DOut is 0 when not selected
//   A2 / DIn / CP0_WE  mtc0 register number / data / write strobe
//   EXL_clr            eret in M; clears SR.EXL
//   PC, BD, ExcCode    M-stage PC, delay-slot flag, exception code (0 = none)
//   HWInt              hardware interrupt lines
//   DOut               mfc0 read data
//   EPCOut             eret target; bypasses an mtc0 to EPC issued in the same cycle
//   Req                take exception/interrupt now (flush + redirect)
module cp0_unit #(
  parameter logic [31:0] PRID     = 32'h4D50_0001,
  parameter logic [31:0] SR_RESET = 32'h0000_FC01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        CP0_WE,
  input  logic        EXL_clr,
  input  logic        CP0_sel,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] R_COUNT   = 5'd9;
  localparam logic [4:0] R_COMPARE = 5'd11;
  localparam logic [4:0] R_SR      = 5'd12;
  localparam logic [4:0] R_CAUSE   = 5'd13;
  localparam logic [4:0] R_EPC     = 5'd14;
  localparam logic [4:0] R_PRID    = 5'd15;

  // SR fields
  logic [5:0]  im;
  logic        exl, ie;

  // Cause fields
  logic        cause_bd;
  logic [4:0]  cause_exc;
  logic [5:0]  cause_ip;

  logic [31:0] epc;
  logic        ti;

  logic [5:0]  ip_next;
  logic        int_req, exc_req, req_i;
  logic        wr_en, clr_en;
  logic [31:0] epc_wr_data, exc_epc;
  logic [31:0] rd_data;

  assign ip_next = HWInt | {ti, 5'b0};
  assign int_req = (|(ip_next & im)) & ie & ~exl;
  assign exc_req = (ExcCode != 5'd0) & ~exl;
  assign req_i   = int_req | exc_req;

  // A trap in flight squashes the M-stage mtc0/eret that would otherwise retire.
  assign wr_en  = CP0_WE  & ~req_i;
  assign clr_en = EXL_clr & ~req_i;

  assign epc_wr_data = DIn & 32'hFFFF_FFFC;
  // A delay-slot trap restarts at the branch; the subtraction wraps modulo 2^32.
  assign exc_epc     = (BD ? (PC - 32'd4) : PC) & 32'hFFFF_FFFC;

  // SR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im  <= SR_RESET[15:10];
      exl <= SR_RESET[1];
      ie  <= SR_RESET[0];
    end else if (req_i) begin
      exl <= 1'b1;
    end else if (wr_en && A2 == R_SR) begin
      im  <= DIn[15:10];
      ie  <= DIn[0];
      // eret in the same cycle wins for EXL only
      exl <= DIn[1] & ~EXL_clr;
    end else if (clr_en) begin
      exl <= 1'b0;
    end
  end

  // Cause: IP samples the lines every cycle. BD and ExcCode change only on a trap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause_bd  <= 1'b0;
      cause_exc <= 5'd0;
      cause_ip  <= 6'd0;
    end else begin
      cause_ip <= ip_next;
      if (req_i) begin
        cause_bd  <= BD;
        cause_exc <= int_req ? 5'd0 : ExcCode;
      end
    end
  end

  // EPC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      epc <= 32'd0;
    else if (req_i)
      epc <= exc_epc;
    else if (wr_en && A2 == R_EPC)
      epc <= epc_wr_data;
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;

  // A Count write replaces that cycle's increment.
  // A Compare write is the only thing that clears TI.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      count <= (wr_en && A2 == R_COUNT) ? DIn : count + 32'd1;
      if (wr_en && A2 == R_COMPARE) begin
        compare <= DIn;
        ti      <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        ti <= 1'b1;
      end
    end
  end
`else
  assign ti = 1'b0;
`endif

  always_comb begin
    rd_data = 32'd0;
    case (A1)
      R_SR:    rd_data = {16'd0, im, 8'd0, exl, ie};
      R_CAUSE: rd_data = {cause_bd, ti, 14'd0, cause_ip, 3'd0, cause_exc, 2'd0};
      R_EPC:   rd_data = epc;
      R_PRID:  rd_data = PRID;
`ifdef CP0_TIMER_EN
      R_COUNT:   rd_data = count;
      R_COMPARE: rd_data = compare;
`endif
      default: rd_data = 32'd0;
    endcase
  end

  // All outputs are forced quiet while reset is held, so a trap aborted by reset
  // drops Req immediately.
  assign Req    = reset & req_i;
  assign DOut   = (reset & CP0_sel) ? rd_data : 32'd0;
  assign EPCOut = !reset ? 32'd0 :
                  (CP0_WE && A2 == R_EPC && !req_i) ? epc_wr_data : epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Testbench for cp0_unit. The bench runs in four phases:
//   1. Directed table of per-cycle vectors.
//   2. Randomised cycles checked against a behavioural model.
//   3. A reset-abort sequence.
//   4. A timer sequence in the CP0_TIMER_EN build, or checks that regs 9/11
//      are dead in the default build.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn, PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        CP0_WE, EXL_clr, CP0_sel;
  logic [31:0] DOut, EPCOut;
  logic        Req;

  int vectors = 0;
  int miscompares = 0;

  cp0_unit dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .PC(PC), .BD(BD),
    .ExcCode(ExcCode), .HWInt(HWInt), .CP0_WE(CP0_WE), .EXL_clr(EXL_clr),
    .CP0_sel(CP0_sel), .DOut(DOut), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural register values as software sees them.
  logic [31:0] m_sr, m_cause, m_epc;

  task automatic m_reset();
    m_sr    = 32'h0000_FC01 & 32'h0000_FC03;
    m_cause = 32'd0;
    m_epc   = 32'd0;
  endtask

  function automatic logic m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((ExcCode != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h4D50_0001;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step();
    logic [31:0] ipv;
    ipv = {16'd0, HWInt, 10'd0};
    if (m_req()) begin
      m_cause = (BD ? 32'h8000_0000 : 32'd0) | ipv |
                (m_int() ? 32'd0 : {27'd0, ExcCode} * 4);
      m_epc   = (BD ? PC - 32'd4 : PC) & ~32'd3;
      m_sr    = m_sr | 32'd2;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ipv;
      if (CP0_WE && A2 == 5'd12) m_sr  = DIn & 32'h0000_FC03;
      if (CP0_WE && A2 == 5'd14) m_epc = DIn & ~32'd3;
      if (EXL_clr) m_sr = m_sr & ~32'd2;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; PC = 32'd0; BD = 1'b0; ExcCode = 5'd0;
    HWInt = 6'd0; CP0_WE = 1'b0; EXL_clr = 1'b0; CP0_sel = 1'b0;
  endtask

  // Advance one clock edge, keeping the model in step, then return at the negedge.
  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]  a1;
    logic        sel;
    logic [4:0]  a2;
    logic        we;
    logic [31:0] din, pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic [31:0] e_dout, e_epco;
    logic        e_req;
  } vec_t;

  function automatic vec_t mk(
    input logic [4:0] a1, input logic sel, input logic [4:0] a2, input logic we,
    input logic [31:0] din, input logic [31:0] pc, input logic bd,
    input logic [4:0] exc, input logic [5:0] hw, input logic clr,
    input logic [31:0] e_dout, input logic [31:0] e_epco, input logic e_req);
    vec_t v;
    v.a1 = a1; v.sel = sel; v.a2 = a2; v.we = we; v.din = din; v.pc = pc; v.bd = bd;
    v.exc = exc; v.hw = hw; v.clr = clr; v.e_dout = e_dout; v.e_epco = e_epco;
    v.e_req = e_req;
    return v;
  endfunction

  vec_t tv[29];

  initial begin
    int found;
    logic [4:0] ra;

    //         a1 sel a2 we  din            pc            bd exc  hw     clr  dout           epco           req
    tv[0]  = mk(12, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h0000_FC01, 32'h0,         0);
    tv[1]  = mk(15, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h4D50_0001, 32'h0,         0);
    // interrupt taken on line 2
    tv[2]  = mk(12, 1, 0, 0, 32'h0,         32'h0000_3010, 0, 0,  6'h04, 0, 32'h0000_FC01, 32'h0,         1);
    tv[3]  = mk(14, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h04, 0, 32'h0000_3010, 32'h0000_3010, 0);
    tv[4]  = mk(13, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h04, 0, 32'h0000_1000, 32'h0000_3010, 0);
    tv[5]  = mk(12, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h0000_FC03, 32'h0000_3010, 0);
    tv[6]  = mk(13, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 1, 32'h0,         32'h0000_3010, 0);
    // exception in delay slot
    tv[7]  = mk(12, 1, 0, 0, 32'h0,         32'h0000_3008, 1, 4,  6'h00, 0, 32'h0000_FC01, 32'h0000_3010, 1);
    tv[8]  = mk(13, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h8000_0010, 32'h0000_3004, 0);
    tv[9]  = mk(14, 1, 0, 0, 32'h0,         32'h0,         0, 5,  6'h00, 0, 32'h0000_3004, 32'h0000_3004, 0);
    tv[10] = mk(12, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 1, 32'h0000_FC03, 32'h0000_3004, 0);
    // interrupt + exception + mtc0 EPC together: interrupt wins, mtc0 dropped
    tv[11] = mk(12, 1,14, 1, 32'hDEAD_BEEF, 32'h0000_2000, 0, 12, 6'h01, 0, 32'h0000_FC01, 32'h0000_3004, 1);
    tv[12] = mk(13, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h0000_0400, 32'h0000_2000, 0);
    // mtc0 EPC bypass, then eret
    tv[13] = mk(14, 1,14, 1, 32'h0000_4007, 32'h0,         0, 0,  6'h00, 0, 32'h0000_2000, 32'h0000_4004, 0);
    tv[14] = mk(14, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 1, 32'h0000_4004, 32'h0000_4004, 0);
    tv[15] = mk(12, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h0000_FC01, 32'h0000_4004, 0);
    // Cause and PRId are read-only
    tv[16] = mk(13, 1,13, 1, 32'hFFFF_FFFF, 32'h0,         0, 0,  6'h00, 0, 32'h0,         32'h0000_4004, 0);
    tv[17] = mk(13, 1,15, 1, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h0,         32'h0000_4004, 0);
    // SR write with EXL=1 plus eret in the same cycle: EXL ends cleared
    tv[18] = mk(15, 1,12, 1, 32'h0000_0402, 32'h0,         0, 0,  6'h00, 1, 32'h4D50_0001, 32'h0000_4004, 0);
    tv[19] = mk(12, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h01, 0, 32'h0000_0400, 32'h0000_4004, 0);
    // delay-slot exception at PC=0 wraps
    tv[20] = mk(12, 1, 0, 0, 32'h0,         32'h0,         1, 1,  6'h00, 0, 32'h0000_0400, 32'h0000_4004, 1);
    tv[21] = mk(14, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
    tv[22] = mk(14, 0, 3, 1, 32'h1234_5678, 32'h0,         0, 0,  6'h00, 0, 32'h0,         32'hFFFF_FFFC, 0);
    tv[23] = mk( 3, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h0,         32'hFFFF_FFFC, 0);
    tv[24] = mk(13, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h8000_0004, 32'hFFFF_FFFC, 0);
    // SR keeps only IM/EXL/IE
    tv[25] = mk(12, 1,12, 1, 32'hFFFF_FFFF, 32'h0,         0, 0,  6'h00, 0, 32'h0000_0402, 32'hFFFF_FFFC, 0);
    tv[26] = mk(12, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h0000_FC03, 32'hFFFF_FFFC, 0);
    tv[27] = mk(12, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 1, 32'h0000_FC03, 32'hFFFF_FFFC, 0);
    tv[28] = mk(12, 1, 0, 0, 32'h0,         32'h0,         0, 0,  6'h00, 0, 32'h0000_FC01, 32'hFFFF_FFFC, 0);

    // Reset: outputs stay quiet even with every interrupt line raised.
    idle();
    reset = 1'b0;
    m_reset();
    HWInt = 6'h3F; CP0_sel = 1'b1; A1 = 5'd12;
    @(negedge clk);
    #1;
    chk("reset_req",  {31'd0, Req}, 32'd0);
    chk("reset_dout", DOut, 32'd0);
    chk("reset_epco", EPCOut, 32'd0);
    @(negedge clk);
    idle();
    reset = 1'b1;

    // Directed table
    foreach (tv[i]) begin
      A1 = tv[i].a1; CP0_sel = tv[i].sel; A2 = tv[i].a2; CP0_WE = tv[i].we;
      DIn = tv[i].din; PC = tv[i].pc; BD = tv[i].bd; ExcCode = tv[i].exc;
      HWInt = tv[i].hw; EXL_clr = tv[i].clr;
      #1;
      chk($sformatf("tv%0d_dout", i), DOut, tv[i].e_dout);
      chk($sformatf("tv%0d_epco", i), EPCOut, tv[i].e_epco);
      chk($sformatf("tv%0d_req", i), {31'd0, Req}, {31'd0, tv[i].e_req});
      tick();
    end

    // Random cycles against the model
    for (int n = 0; n < 400; n++) begin
      HWInt   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      ExcCode = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      CP0_WE  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: ra = 5'd12;
        1: ra = 5'd13;
        2: ra = 5'd14;
        3: ra = 5'd15;
        default: ra = 5'($urandom);
      endcase
`ifdef CP0_TIMER_EN
      if (ra == 5'd9 || ra == 5'd11) ra = 5'd14;
`endif
      A2 = ra;
      DIn = $urandom;
      EXL_clr = ($urandom_range(0, 5) == 0);
      CP0_sel = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
`ifdef CP0_TIMER_EN
      if (ra == 5'd9) ra = 5'd12;
`endif
      A1 = ra;
      PC = $urandom;
      BD = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_dout", DOut, CP0_sel ? m_read(A1) : 32'd0);
      chk("rnd_epco", EPCOut, (CP0_WE && A2 == 5'd14 && !m_req()) ? (DIn & ~32'd3) : m_epc);
      chk("rnd_req",  {31'd0, Req}, {31'd0, m_req()});
      tick();
    end

    // A reset asserted while an interrupt is pending drops Req at once and
    // leaves EXL untouched.
    idle();
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    HWInt = 6'h3F; CP0_sel = 1'b1; A1 = 5'd12;
    #1;
    chk("pre_abort_req", {31'd0, Req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_req",  {31'd0, Req}, 32'd0);
    chk("abort_dout", DOut, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    HWInt = 6'h00;
    #1;
    chk("abort_sr", DOut, 32'h0000_FC01);
    chk("abort_req_after", {31'd0, Req}, 32'd0);
    tick();

`ifdef CP0_TIMER_EN
    // Move Count away from the target, set Compare=5, then zero Count. Count is n
    // during the n-th cycle afterwards; TI registers the match one cycle later,
    // so Req is first seen at n=6.
    idle(); CP0_WE = 1'b1; A2 = 5'd9;  DIn = 32'd1000; tick();
    idle(); CP0_WE = 1'b1; A2 = 5'd11; DIn = 32'd5;    tick();
    idle(); CP0_WE = 1'b1; A2 = 5'd9;  DIn = 32'd0;    tick();
    idle();
    found = -1;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (Req) begin
        found = n;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("timer_req_cycle", 32'(found), 32'd6);
    @(posedge clk);
    @(negedge clk);
    CP0_sel = 1'b1; A1 = 5'd13; CP0_WE = 1'b1; A2 = 5'd11; DIn = 32'd0;
    #1;
    chk("timer_ti_set", {31'd0, DOut[30]}, 32'd1);
    chk("timer_ip15",   {31'd0, DOut[15]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    CP0_WE = 1'b0;
    #1;
    chk("timer_ti_clr", {31'd0, DOut[30]}, 32'd0);
`else
    // Without the timer, registers 9 and 11 are dead.
    idle(); CP0_WE = 1'b1; A2 = 5'd9;  DIn = 32'hFFFF_FFFF; tick();
    idle(); CP0_WE = 1'b1; A2 = 5'd11; DIn = 32'h0000_0003; tick();
    idle(); CP0_sel = 1'b1; A1 = 5'd9;
    #1;
    chk("count_dead", DOut, 32'd0);
    tick();
    CP0_sel = 1'b1; A1 = 5'd11;
    #1;
    chk("compare_dead", DOut, 32'd0);
    tick();
    CP0_sel = 1'b1; A1 = 5'd13;
    #1;
    chk("ti_dead", {31'd0, DOut[30]}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- System coprocessor 0 for the pipelined MIPS core; sits directly downstream of the M-stage control decode.
- Consumes its CP0 write-enable, EXL-clear and CP0-select strobes together with M-stage PC, branch-delay flag and exception code.
- Holds SR, Cause, EPC and PRId.
- Arbitrates hardware interrupts against synchronous exceptions and drives the pipeline flush/redirect request plus the EPC used by eret.

Parameters:
PRID, 32'h4D50_0001, constant value returned for register 15.
SR_RESET, 32'h0000_FC01, reset value of SR's writable bits (IM=6'h3F, EXL=0, IE=1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
A1  input  5  mfc0 read register number (rd field).
A2  input  5  mtc0 write register number (rd field).
DIn  input  32  mtc0 write data.
PC  input  32  M-stage instruction PC.
BD  input  1  M-stage instruction is in a branch delay slot.
ExcCode  input  5  M-stage exception code; 0 = none.
HWInt  input  6  hardware interrupt lines, level sensitive.
CP0_WE  input  1  mtc0 in M.
EXL_clr  input  1  eret in M.
CP0_sel  input  1  mfc0 in M; gates DOut.
DOut  output  32  mfc0 read data.
EPCOut  output  32  eret target.
Req  output  1  take exception/interrupt this cycle (flush and redirect).

Behaviour:
- Reset (reset=0, async):
  - SR = SR_RESET & 32'h0000_FC03.
  - Cause = 0, EPC = 0.
  - Timer registers = 0 when compiled in.
  - All outputs derive from these: DOut=0, Req=0, EPCOut=0.
- SR (12): only IM[15:10], EXL[1] and IE[0] are stored; all other bits read 0.
- Cause (13):
  - BD[31], TI[30] (timer build only), IP[15:10], ExcCode[6:2]; others read 0.
  - IP is overwritten every cycle with the current HWInt (OR'd with TI into IP[15] in the timer build).
  - Cause is not software writable; mtc0 to 13 is ignored.
- EPC (14): stored word-aligned; a write stores {DIn[31:2],2'b00}.
- PRId (15): reads PRID; writes ignored.
- Unimplemented registers read 0 and writes to them are ignored.
- IntReq = |(IP_next & IM) & IE & ~EXL, where IP_next is the combinational HWInt (plus TI).
- ExcReq = (ExcCode != 0) & ~EXL.
- Req = IntReq | ExcReq, combinational, same cycle.
- On a clock edge with Req=1:
  - EXL <= 1.
  - ExcCode <= (IntReq ? 5'd0 : ExcCode). An interrupt has priority over a simultaneous exception.
  - Cause.BD <= BD.
  - EPC <= BD ? (PC-4) word-aligned : PC word-aligned.
  - A concurrent mtc0 or eret is suppressed.
- Otherwise, on a clock edge:
  - CP0_WE=1 writes register A2.
  - EXL_clr=1 clears EXL.
  - If CP0_WE writes SR and EXL_clr is also 1 in the same cycle, EXL_clr wins for the EXL bit and the written IM/IE take effect.
- DOut = CP0_sel ? reg[A1] : 0. The read is combinational with no write-to-read bypass; an mtc0 result is visible the cycle after.
- EPCOut = (CP0_WE & A2==14 & ~Req) ? {DIn[31:2],2'b00} : EPC. This bypass covers mtc0 EPC immediately followed by eret.
- EPC arithmetic is 32-bit modulo. BD with PC=0 yields 32'hFFFF_FFFC.
- Reset asserted mid-exception aborts all updates; Req falls immediately.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined:
  - Count (9) is a 32-bit register incrementing every cycle and wrapping at 2^32.
  - Compare (11) is a 32-bit register.
  - When Count==Compare and Compare!=0, TI is set and stays set until Compare is written.
  - Count and Compare are writable via mtc0. A Count write overrides that cycle's increment.
  - TI ORs into IP[15] and can raise IntReq.
- When undefined: registers 9 and 11 read 0, writes are ignored, and TI and Cause[30] are constant 0.

Test Plan:
- Reset with reset=0, then release → DOut(A1=12, CP0_sel=1) = 32'h0000_FC01; A1=15 reads 32'h4D50_0001; Req=0.
- Interrupt taken: HWInt=6'b000100, IM=3F, IE=1, PC=32'h0000_3010, BD=0 → Req=1 that cycle. Next cycle:
  - EPC = 32'h0000_3010.
  - Cause[6:2] = 0, Cause[12] = 1.
  - SR.EXL = 1 and Req = 0.
- Exception in delay slot: ExcCode=5'd4, BD=1, PC=32'h0000_3008 → EPC = 32'h0000_3004, Cause[31] = 1, ExcCode = 4.
- Simultaneous interrupt and exception: HWInt=1, ExcCode=12, CP0_WE=1, A2=14, DIn=32'hDEAD_BEEF → ExcCode = 0 and EPC = PC; the mtc0 is dropped.
- mtc0 EPC bypass and eret: CP0_WE=1, A2=14, DIn=32'h0000_4007 → EPCOut = 32'h0000_4004 the same cycle. EXL_clr the next cycle → EXL = 0.
- CP0_TIMER_EN: write Compare=5 and Count=0 → TI set 5 cycles later and Req asserts (IM[15]=1). Writing Compare clears TI.
